// File: rtl/reaction_game_pkg.sv
// Types and helpers shared by the reaction-time game controller and its game clock.
package reaction_game_pkg;

    typedef enum logic [2:0] {IDLE, GAP, SHOW, SCORE, DONE} game_state_t;

    localparam int SCORE_MAX = 99;

    function automatic int width_of(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reduction is compared against the base first so the subtraction never wraps.
    function automatic int on_ms(input int lvl, input int base_ms, input int step_ms, input int min_ms);
        int cut;
        cut = step_ms * lvl;
        if (cut >= base_ms)
            return min_ms;
        return max_int(base_ms - cut, min_ms);
    endfunction

endpackage

// File: rtl/game_clock.sv
// Millisecond-to-second prescaler and the game's seconds-remaining down-counter.
module game_clock
    import reaction_game_pkg::*;
#(
    parameter int GAME_SECONDS = 60,
    parameter int SEC_W        = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic             tick_ms,
    output logic [SEC_W-1:0] seconds_left,
    output logic             expired
);

    localparam int PRE_W = width_of(999);

    logic [PRE_W-1:0] ms_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_cnt       <= '0;
            seconds_left <= SEC_W'(GAME_SECONDS);
        end else if (load) begin
            ms_cnt       <= '0;
            seconds_left <= SEC_W'(GAME_SECONDS);
        end else if (enable && tick_ms && (seconds_left != '0)) begin
            if (ms_cnt == PRE_W'(999)) begin
                ms_cnt       <= '0;
                seconds_left <= seconds_left - 1'b1;
            end else begin
                ms_cnt <= ms_cnt + 1'b1;
            end
        end
    end

    assign expired = (seconds_left == '0);

endmodule

// File: rtl/reaction_game_ctrl.sv
// Multi-target reaction game: round FSM, target mask generation and score/level/miss tracking.
module reaction_game_ctrl
    import reaction_game_pkg::*;
#(
    parameter int LED_NUM        = 18,
    parameter int MAX_TARGETS    = 3,
    parameter int GAME_SECONDS   = 60,
    parameter int BASE_ON_MS     = 1000,
    parameter int LEVEL_STEP_MS  = 200,
    parameter int MIN_ON_MS      = 200,
    parameter int HITS_PER_LEVEL = 5,
    parameter int MAX_LEVEL      = 7,
    parameter int MIN_GAP_MS     = 250
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick_ms,
    input  logic                       start_edge,
    input  logic [$clog2(LED_NUM)-1:0] rand_idx,
    input  logic [9:0]                 rand_delay,
    input  logic [LED_NUM-1:0]         switches,
    output logic [LED_NUM-1:0]         led_on,
    output logic [6:0]                 user_score,
    output logic [3:0]                 level,
    output logic [6:0]                 misses,
    output logic [5:0]                 seconds_left,
    output logic                       playing,
    output logic                       done
);

    localparam int STRIDE = LED_NUM / MAX_TARGETS;
    localparam int CNT_W  = width_of(max_int(MIN_GAP_MS + 1023, BASE_ON_MS));
    localparam logic [LED_NUM-1:0] ONE_BIT = LED_NUM'(1);

    function automatic logic [6:0] sat_add(input logic [6:0] a, input int b);
        int s;
        s = int'(a) + b;
        return (s > SCORE_MAX) ? 7'(SCORE_MAX) : 7'(s);
    endfunction

    function automatic logic [6:0] sat_dec(input logic [6:0] a);
        return (a == '0) ? a : a - 7'd1;
    endfunction

    function automatic logic [3:0] level_of(input logic [6:0] s);
        int l;
        l = int'(s) / HITS_PER_LEVEL;
        return (l > MAX_LEVEL) ? 4'(MAX_LEVEL) : 4'(l);
    endfunction

    game_state_t        state;
    logic [CNT_W-1:0]   round_cnt;
    logic [CNT_W-1:0]   gap_load;
    logic [CNT_W-1:0]   on_load;
    logic [LED_NUM-1:0] mask;
    logic [LED_NUM-1:0] snap;
    logic [LED_NUM-1:0] mask_new;
    logic [LED_NUM-1:0] diff;
    logic [6:0]         score_hit;
    logic               hit;
    logic               wrong;
    logic               expired;
    logic               clk_en;
    logic               clk_load;
    int                 k_cur;

    always_comb begin
        k_cur = int'(level) + 1;
        if (k_cur > MAX_TARGETS)
            k_cur = MAX_TARGETS;
    end

    // Targets are spread STRIDE apart, so every position stays below 2*LED_NUM and one wrap suffices.
    always_comb begin
        int base;
        int pos;
        base = int'(rand_idx);
        if (base >= LED_NUM)
            base = base - LED_NUM;
        mask_new = '0;
        for (int i = 0; i < MAX_TARGETS; i++) begin
            pos = base + i * STRIDE;
            if (pos >= LED_NUM)
                pos = pos - LED_NUM;
            if (i < k_cur)
                mask_new = mask_new | (ONE_BIT << pos);
        end
    end

    assign gap_load  = CNT_W'(MIN_GAP_MS + int'(rand_delay));
    assign on_load   = CNT_W'(on_ms(int'(level), BASE_ON_MS, LEVEL_STEP_MS, MIN_ON_MS));
    assign diff      = switches ^ snap;
    assign hit       = (diff == mask);
    assign wrong     = |(diff & ~mask);
    assign score_hit = sat_add(user_score, k_cur);
    assign clk_en    = (state == GAP) || (state == SHOW) || (state == SCORE);
    assign clk_load  = (state == IDLE) && start_edge;

    game_clock #(
        .GAME_SECONDS (GAME_SECONDS),
        .SEC_W        (6)
    ) u_clock (
        .clk          (clk),
        .reset        (reset),
        .enable       (clk_en),
        .load         (clk_load),
        .tick_ms      (tick_ms),
        .seconds_left (seconds_left),
        .expired      (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            round_cnt  <= '0;
            mask       <= '0;
            snap       <= '0;
            user_score <= '0;
            level      <= '0;
            misses     <= '0;
            led_on     <= '0;
            playing    <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        user_score <= '0;
                        level      <= '0;
                        misses     <= '0;
                        round_cnt  <= gap_load;
                        playing    <= 1'b1;
                        state      <= GAP;
                    end
                end
                DONE: begin
                    if (start_edge) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    // Abort and expiry outrank anything the round itself would do this cycle.
                    if (start_edge) begin
                        led_on  <= '0;
                        playing <= 1'b0;
                        state   <= IDLE;
                    end else if (expired) begin
                        led_on  <= '0;
                        playing <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        case (state)
                            GAP: begin
                                if (round_cnt == '0) begin
                                    snap      <= switches;
                                    mask      <= mask_new;
                                    led_on    <= mask_new;
                                    round_cnt <= on_load;
                                    state     <= SHOW;
                                end else if (tick_ms) begin
                                    round_cnt <= round_cnt - 1'b1;
                                end
                            end
                            SHOW: begin
                                if (hit) begin
                                    led_on <= '0;
                                    state  <= SCORE;
                                end else if (wrong || (round_cnt == '0)) begin
                                    misses    <= sat_add(misses, 1);
                                    if (wrong)
                                        user_score <= sat_dec(user_score);
                                    led_on    <= '0;
                                    round_cnt <= gap_load;
                                    state     <= GAP;
                                end else if (tick_ms) begin
                                    round_cnt <= round_cnt - 1'b1;
                                end
                            end
                            SCORE: begin
                                user_score <= score_hit;
                                level      <= level_of(score_hit);
                                round_cnt  <= gap_load;
                                state      <= GAP;
                            end
                            default: begin
                                playing <= 1'b0;
                                state   <= IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed bench for reaction_game_ctrl with hand-computed expectations at default parameters.
module tb_reaction_game_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_ms;
    logic        start_edge;
    logic [4:0]  rand_idx;
    logic [9:0]  rand_delay;
    logic [17:0] switches;
    logic [17:0] led_on;
    logic [6:0]  user_score;
    logic [3:0]  level;
    logic [6:0]  misses;
    logic [5:0]  seconds_left;
    logic        playing;
    logic        done;

    int n_pass  = 0;
    int n_total = 0;

    reaction_game_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .tick_ms      (tick_ms),
        .start_edge   (start_edge),
        .rand_idx     (rand_idx),
        .rand_delay   (rand_delay),
        .switches     (switches),
        .led_on       (led_on),
        .user_score   (user_score),
        .level        (level),
        .misses       (misses),
        .seconds_left (seconds_left),
        .playing      (playing),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        tick_ms = 1'b1;
        cyc(n);
        tick_ms = 1'b0;
    endtask

    task automatic press();
        start_edge = 1'b1;
        cyc(1);
        start_edge = 1'b0;
    endtask

    task automatic to_show(input int gap);
        ticks(gap);
        cyc(1);
    endtask

    task automatic hit_round(input logic [17:0] m);
        to_show(250);
        switches = switches ^ m;
        cyc(2);
    endtask

    task automatic test_reset();
        n_total++; if (led_on !== 18'h0) $display("FAIL rst_led: got %h want 0", led_on); else n_pass++;
        n_total++; if (user_score !== 7'd0) $display("FAIL rst_score: got %0d want 0", user_score); else n_pass++;
        n_total++; if (level !== 4'd0) $display("FAIL rst_level: got %0d want 0", level); else n_pass++;
        n_total++; if (misses !== 7'd0) $display("FAIL rst_misses: got %0d want 0", misses); else n_pass++;
        n_total++; if (seconds_left !== 6'd60) $display("FAIL rst_seconds: got %0d want 60", seconds_left); else n_pass++;
        n_total++; if (playing !== 1'b0) $display("FAIL rst_playing: got %b want 0", playing); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
        reset = 1'b0;
        cyc(1);
        press();
        n_total++; if (playing !== 1'b1) $display("FAIL start_playing: got %b want 1", playing); else n_pass++;
        to_show(250);
        ticks(800);
        n_total++; if (led_on !== 18'h00010) $display("FAIL rst_show_led: got %h want 00010", led_on); else n_pass++;
        n_total++; if (seconds_left !== 6'd59) $display("FAIL rst_show_sec: got %0d want 59", seconds_left); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++; if (led_on !== 18'h0) $display("FAIL async_led: got %h want 0", led_on); else n_pass++;
        n_total++; if (playing !== 1'b0) $display("FAIL async_playing: got %b want 0", playing); else n_pass++;
        n_total++; if (seconds_left !== 6'd60) $display("FAIL async_seconds: got %0d want 60", seconds_left); else n_pass++;
        cyc(1);
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_single_hit();
        press();
        ticks(250);
        n_total++; if (led_on !== 18'h0) $display("FAIL gap_dark: got %h want 0", led_on); else n_pass++;
        cyc(1);
        n_total++; if (led_on !== 18'h00010) $display("FAIL single_led: got %h want 00010", led_on); else n_pass++;
        ticks(100);
        switches[4] = ~switches[4];
        cyc(1);
        n_total++; if (led_on !== 18'h0) $display("FAIL score_led: got %h want 0", led_on); else n_pass++;
        n_total++; if (user_score !== 7'd0) $display("FAIL score_lat: got %0d want 0", user_score); else n_pass++;
        cyc(1);
        n_total++; if (user_score !== 7'd1) $display("FAIL single_score: got %0d want 1", user_score); else n_pass++;
        n_total++; if (level !== 4'd0) $display("FAIL single_level: got %0d want 0", level); else n_pass++;
    endtask

    task automatic test_multi_target();
        repeat (4) hit_round(18'h00010);
        n_total++; if (level !== 4'd1) $display("FAIL lvl1: got %0d want 1", level); else n_pass++;
        repeat (2) hit_round(18'h00410);
        n_total++; if (user_score !== 7'd9) $display("FAIL score9: got %0d want 9", user_score); else n_pass++;
        rand_idx = 5'd17;
        to_show(250);
        n_total++; if (led_on !== 18'h20020) $display("FAIL mask_17_5: got %h want 20020", led_on); else n_pass++;
        switches[17] = ~switches[17];
        cyc(2);
        n_total++; if (led_on !== 18'h20020) $display("FAIL partial_show: got %h want 20020", led_on); else n_pass++;
        n_total++; if (user_score !== 7'd9) $display("FAIL partial_score: got %0d want 9", user_score); else n_pass++;
        switches[5] = ~switches[5];
        cyc(2);
        n_total++; if (user_score !== 7'd11) $display("FAIL score11: got %0d want 11", user_score); else n_pass++;
        n_total++; if (level !== 4'd2) $display("FAIL lvl2: got %0d want 2", level); else n_pass++;
        rand_idx = 5'd20;
        to_show(250);
        n_total++; if (led_on !== 18'h04104) $display("FAIL mask_wrap_idx: got %h want 04104", led_on); else n_pass++;
        switches = switches ^ 18'h04104;
        cyc(2);
        n_total++; if (user_score !== 7'd14) $display("FAIL score14: got %0d want 14", user_score); else n_pass++;
        rand_idx = 5'd4;
        repeat (2) hit_round(18'h10410);
        n_total++; if (user_score !== 7'd20) $display("FAIL score20: got %0d want 20", user_score); else n_pass++;
        n_total++; if (level !== 4'd4) $display("FAIL lvl4: got %0d want 4", level); else n_pass++;
    endtask

    task automatic test_timeout();
        to_show(250);
        n_total++; if (led_on !== 18'h10410) $display("FAIL to_mask: got %h want 10410", led_on); else n_pass++;
        ticks(199);
        cyc(1);
        n_total++; if (led_on !== 18'h10410) $display("FAIL to_199: got %h want 10410", led_on); else n_pass++;
        ticks(1);
        n_total++; if (misses !== 7'd0) $display("FAIL to_200_misses: got %0d want 0", misses); else n_pass++;
        cyc(1);
        n_total++; if (misses !== 7'd1) $display("FAIL to_misses: got %0d want 1", misses); else n_pass++;
        n_total++; if (led_on !== 18'h0) $display("FAIL to_led: got %h want 0", led_on); else n_pass++;
        n_total++; if (user_score !== 7'd20) $display("FAIL to_score: got %0d want 20", user_score); else n_pass++;
    endtask

    task automatic test_abort_and_wrong();
        press();
        n_total++; if (playing !== 1'b0) $display("FAIL abort_playing: got %b want 0", playing); else n_pass++;
        n_total++; if (user_score !== 7'd20) $display("FAIL abort_score: got %0d want 20", user_score); else n_pass++;
        press();
        n_total++; if (user_score !== 7'd0) $display("FAIL restart_score: got %0d want 0", user_score); else n_pass++;
        n_total++; if (misses !== 7'd0) $display("FAIL restart_misses: got %0d want 0", misses); else n_pass++;
        n_total++; if (level !== 4'd0) $display("FAIL restart_level: got %0d want 0", level); else n_pass++;
        to_show(250);
        switches[0] = ~switches[0];
        cyc(1);
        n_total++; if (user_score !== 7'd0) $display("FAIL wrong0_score: got %0d want 0", user_score); else n_pass++;
        n_total++; if (misses !== 7'd1) $display("FAIL wrong0_misses: got %0d want 1", misses); else n_pass++;
        n_total++; if (led_on !== 18'h0) $display("FAIL wrong0_led: got %h want 0", led_on); else n_pass++;
        repeat (3) hit_round(18'h00010);
        n_total++; if (user_score !== 7'd3) $display("FAIL score3: got %0d want 3", user_score); else n_pass++;
        to_show(250);
        switches[0] = ~switches[0];
        rand_delay = 10'd5;
        cyc(1);
        rand_delay = 10'd0;
        n_total++; if (user_score !== 7'd2) $display("FAIL wrong3_score: got %0d want 2", user_score); else n_pass++;
        n_total++; if (misses !== 7'd2) $display("FAIL wrong3_misses: got %0d want 2", misses); else n_pass++;
        ticks(254);
        cyc(1);
        n_total++; if (led_on !== 18'h0) $display("FAIL gap255_early: got %h want 0", led_on); else n_pass++;
        ticks(1);
        cyc(1);
        n_total++; if (led_on !== 18'h00010) $display("FAIL gap255_show: got %h want 00010", led_on); else n_pass++;
    endtask

    task automatic test_expiry();
        press();
        press();
        n_total++; if (seconds_left !== 6'd60) $display("FAIL exp_load: got %0d want 60", seconds_left); else n_pass++;
        hit_round(18'h00010);
        repeat (47) begin
            to_show(250);
            ticks(1000);
            cyc(1);
        end
        to_show(250);
        ticks(749);
        n_total++; if (seconds_left !== 6'd1) $display("FAIL exp_sec1: got %0d want 1", seconds_left); else n_pass++;
        ticks(1);
        n_total++; if (seconds_left !== 6'd0) $display("FAIL exp_sec0: got %0d want 0", seconds_left); else n_pass++;
        n_total++; if (led_on !== 18'h00010) $display("FAIL exp_show: got %h want 00010", led_on); else n_pass++;
        switches[4] = ~switches[4];
        cyc(1);
        n_total++; if (done !== 1'b1) $display("FAIL exp_done: got %b want 1", done); else n_pass++;
        n_total++; if (playing !== 1'b0) $display("FAIL exp_playing: got %b want 0", playing); else n_pass++;
        n_total++; if (led_on !== 18'h0) $display("FAIL exp_led: got %h want 0", led_on); else n_pass++;
        n_total++; if (misses !== 7'd47) $display("FAIL exp_misses: got %0d want 47", misses); else n_pass++;
        cyc(3);
        n_total++; if (user_score !== 7'd1) $display("FAIL exp_no_score: got %0d want 1", user_score); else n_pass++;
        press();
        n_total++; if (done !== 1'b0) $display("FAIL done_idle: got %b want 0", done); else n_pass++;
        n_total++; if (user_score !== 7'd1) $display("FAIL done_held: got %0d want 1", user_score); else n_pass++;
        press();
        n_total++; if (user_score !== 7'd0) $display("FAIL new_game_score: got %0d want 0", user_score); else n_pass++;
        n_total++; if (misses !== 7'd0) $display("FAIL new_game_misses: got %0d want 0", misses); else n_pass++;
        n_total++; if (seconds_left !== 6'd60) $display("FAIL new_game_sec: got %0d want 60", seconds_left); else n_pass++;
    endtask

    initial begin
        reset      = 1'b1;
        tick_ms    = 1'b0;
        start_edge = 1'b0;
        rand_idx   = 5'd4;
        rand_delay = 10'd0;
        switches   = '0;
        cyc(2);
        test_reset();
        test_single_hit();
        test_multi_target();
        test_timeout();
        test_abort_and_wrong();
        test_expiry();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reaction_game_ctrl.md
# reaction_game_ctrl

Parametrised successor to the single-target reaction-time game controller. It runs a timed game that lights one or more target LEDs per round and checks the player's switch toggles against the lit pattern. It scores hits, penalises wrong toggles, counts timeouts, and raises the level so the LEDs stay lit for less time. The block owns its round and game timers, driven by a 1 ms tick strobe, and sits between the LFSR/tick generators and the LED/seven-segment display drivers.

## Interface
- `LED_NUM`, 18: number of LEDs/switches, ≥ `MAX_TARGETS`
- `MAX_TARGETS`, 3: maximum simultaneously lit targets
- `GAME_SECONDS`, 60: game length in seconds
- `BASE_ON_MS`, 1000: LED-on window at level 0
- `LEVEL_STEP_MS`, 200: on-window reduction per level
- `MIN_ON_MS`, 200: floor on the on-window
- `HITS_PER_LEVEL`, 5: score points per level
- `MAX_LEVEL`, 7: level saturation
- `MIN_GAP_MS`, 250: minimum dark gap between rounds
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high reset
- `tick_ms` in 1: single-cycle strobe, once per ms
- `start_edge` in 1: debounced button rising edge
- `rand_idx` in `$clog2(LED_NUM)`: LFSR target index
- `rand_delay` in 10: LFSR gap extension, ms
- `switches` in `LED_NUM`: synchronised switch levels
- `led_on` out `LED_NUM`: target LEDs
- `user_score` out 7: score, saturating at 99
- `level` out 4: current level
- `misses` out 7: timeouts plus wrong toggles, saturating at 99
- `seconds_left` out 6: game time remaining
- `playing` out 1: game in progress
- `done` out 1: game over

## Operation
- States (shared enum): `IDLE`, `GAP`, `SHOW`, `SCORE`, `DONE`.
- Reset values: state `IDLE`; all counters and outputs 0 except `seconds_left` = `GAME_SECONDS`.
- `IDLE`:
  - On `start_edge`, clear score, level and misses, load `seconds_left`, and go to `GAP`.
- `GAP`:
  - On entry, load the round counter with `MIN_GAP_MS + rand_delay`.
  - Decrement the counter on each `tick_ms`.
  - When it reaches 0, snapshot `switches`, latch the target mask, load the counter with `on_ms`, and go to `SHOW`.
- Target mask:
  - `k = min(level+1, MAX_TARGETS)` bits.
  - Bit i (i < k) is at `(idx + i*(LED_NUM/MAX_TARGETS)) mod LED_NUM`.
  - `idx` is `rand_idx`, minus `LED_NUM` when `rand_idx` ≥ `LED_NUM`.
  - These positions are always distinct.
- `on_ms = max(BASE_ON_MS - LEVEL_STEP_MS*level, MIN_ON_MS)`, computed without underflow.
- `SHOW`:
  - Let `diff = switches ^ snapshot`.
  - `diff == mask` (hit): go to `SCORE`.
  - Any `diff` bit outside the mask (wrong): misses+1, score−1 (saturating at 0), go to `GAP`.
  - Round counter reaches 0 (timeout): misses+1, go to `GAP`.
  - A partial correct subset keeps the state in `SHOW`.
- `SCORE`:
  - Score += k, saturating at 99.
  - `level = min(score/HITS_PER_LEVEL, MAX_LEVEL)`, recomputed from the new score.
  - Go to `GAP`.
- Game clock:
  - A ms counter runs on `tick_ms` while in `GAP`, `SHOW` or `SCORE`.
  - Every 1000 ticks, decrement `seconds_left`.
  - When `seconds_left` reaches 0, go to `DONE`.
- `DONE`:
  - `led_on` = 0, `done` = 1, score and misses held.
  - `start_edge` goes to `IDLE`.
- `start_edge` in `GAP`, `SHOW` or `SCORE` aborts the game to `IDLE` (score held, `playing` = 0).
- Same-cycle priority: `reset` > abort > game expiry > hit > wrong > timeout.
  - A hit in the expiry cycle is not scored.
- `led_on = mask` only in `SHOW`; 0 in every other state.
- `playing` = 1 in `GAP`, `SHOW` and `SCORE`.

## Timing
- All state and counters registered.
- Outputs are decodes of registered state, with no input-to-output combinational path.
- `start_edge` in `IDLE` at cycle n gives `GAP` and `playing` = 1 at n+1.
- From the `SHOW` cycle in which the hit is seen, `user_score` updates 2 cycles later (through `SCORE`).
- Wrong and timeout update `misses` 1 cycle later.
- The round counter treats a load and a `tick_ms` in the same cycle as a load.
- `seconds_left` hitting 0 enters `DONE` on the next cycle.
- An asynchronous `reset` mid-round forces `IDLE` and clears `led_on` immediately.

## Structure
- `reaction_game_pkg`:
  - state enum `game_state_t`
  - `SCORE_MAX` = 99
  - `clog2`-based width helpers
  - `on_ms` function
- Sub-module `game_clock`:
  - ms→second prescaler plus the `seconds_left` down-counter
  - ports: enable, load, `tick_ms`, `expired`
- The FSM, mask generator and score/level logic stay in `reaction_game_ctrl`.

## Test plan
- Reset during `SHOW` with `led_on` nonzero → `led_on` = 0 and state `IDLE` before the next edge; `seconds_left` = 60.
- Level 0, `rand_idx` = 4, `rand_delay` = 0, toggle sw4 at 100 ms → `led_on` = bit4 for 250 ms after start, then score 1, level 0.
- Score 9 → level 1, k = 2, `rand_idx` = 17 → mask bits 17 and 5; toggle only sw17 → stays in `SHOW`; then toggle sw5 → score 11, level 2.
- In `SHOW`, toggle a non-target switch with score 0 → score stays 0, misses 1; with score 3 → score 2.
- No toggle at level 4 → timeout after exactly 200 ms of ticks (floored), misses+1.
- Game runs 60,000 ticks → `DONE`, `done` = 1, score held.
  - A hit coinciding with expiry is not counted.
  - `start_edge` → `IDLE`, next `start_edge` clears the score.
